// File: rtl/mem_stage_win_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared types and constants for the windowed memory stage:
//             refill FSM state encoding, SDRAM burst direction encodings,
//             the "no writeback" register tag and a saturating increment.
//  Revision : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    // Refill / writeback sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WB_REQ    = 3'd1,
        ST_WB_DATA   = 3'd2,
        ST_FILL_REQ  = 3'd3,
        ST_FILL_DATA = 3'd4
    } state_t;

    // Burst direction seen by the SDRAM controller on sd_rnw
    localparam logic SD_FILL = 1'b1;
    localparam logic SD_WB   = 1'b0;

    // Register tag meaning "nothing to write back"
    localparam int TAG_NONE = 0;

    // 32-bit increment that sticks at all-ones
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_win_ram.sv
`default_nettype none
// ============================================================================
//  Module   : win_ram
//  Purpose  : Window storage, 2^WIN_AW entries of DW bits. One synchronous
//             write port, two asynchronous read ports (stage lookup and
//             writeback streaming).
//  Revision : 1.0  initial release
// ============================================================================
module win_ram #(
    parameter int DW     = 8,
    parameter int WIN_AW = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [WIN_AW-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [WIN_AW-1:0] raddr_a_i,
    output logic [DW-1:0]     rdata_a_o,
    input  logic [WIN_AW-1:0] raddr_b_i,
    output logic [DW-1:0]     rdata_b_o
);

    localparam int DEPTH = 2 ** WIN_AW;

    logic [DW-1:0] mem_q [0:DEPTH-1];

    // Single write port shared by refill beats and store hits
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/mem_stage_win.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_win
//  Purpose  : Pipeline memory stage backed by one cached SDRAM window.
//             Loads/stores that hit the window complete in one cycle; a miss
//             stalls upstream while the dirty window is written back and the
//             new window is refilled. NCH pass-through result channels are
//             registered into the MEM/WB boundary alongside.
//  Options  : define MEM_PERF_CNT_EN to build the miss / writeback / stall
//             performance counters; otherwise those ports read zero.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_win
    import mem_stage_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 25,
    parameter int WIN_AW = 8,
    parameter int NCH    = 3,
    parameter int PW     = 16,
    parameter int TW     = 5
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic [NCH*PW-1:0] pt_data_in,
    input  logic [NCH*TW-1:0] pt_tag_in,
    output logic [NCH*PW-1:0] pt_data_out,
    output logic [NCH*TW-1:0] pt_tag_out,
    input  logic              ls_valid,
    input  logic              ls_rnw,
    input  logic [AW-1:0]     ls_addr,
    input  logic [DW-1:0]     ls_wdata,
    input  logic [TW-1:0]     ls_tag_in,
    output logic [TW-1:0]     ls_tag_out,
    output logic [DW-1:0]     wb_data,
    output logic              wb_valid,
    output logic              stall,
    output logic              sd_req,
    input  logic              sd_ack,
    output logic              sd_rnw,
    output logic [AW-1:0]     sd_start_addr,
    output logic [AW-1:0]     sd_length,
    input  logic              sd_rvalid,
    input  logic [DW-1:0]     sd_rdata,
    input  logic              sd_wready,
    output logic [DW-1:0]     sd_wdata,
    output logic [31:0]       miss_cnt,
    output logic [31:0]       wb_cnt,
    output logic [31:0]       stall_cnt
);

    localparam int                TAGW      = AW - WIN_AW;
    localparam logic [WIN_AW-1:0] OFS_ZERO  = '0;
    localparam logic [WIN_AW-1:0] CNT_ONE   = WIN_AW'(1);
    localparam logic [WIN_AW-1:0] CNT_LAST  = '1;
    localparam logic [AW-1:0]     BURST_LEN = AW'(2 ** WIN_AW);

    state_t              state_q;
    logic [TAGW-1:0]     win_tag_q;
    logic                win_valid_q;
    logic                dirty_q;
    logic [WIN_AW-1:0]   cnt_q;
    logic                sd_req_q;
    logic                sd_rnw_q;
    logic [AW-1:0]       sd_addr_q;

    logic [NCH*PW-1:0]   pt_data_q;
    logic [NCH*TW-1:0]   pt_tag_q;
    logic [TW-1:0]       ls_tag_q;
    logic [DW-1:0]       wb_data_q;
    logic                wb_valid_q;

    logic [TAGW-1:0]     req_tag;
    logic                hit;
    logic                miss;
    logic                ram_we;
    logic [WIN_AW-1:0]   ram_waddr;
    logic [DW-1:0]       ram_wdata;
    logic [DW-1:0]       stage_rdata;
    logic [DW-1:0]       wb_rdata;

    assign req_tag = ls_addr[AW-1:WIN_AW];
    assign hit     = win_valid_q && (req_tag == win_tag_q);
    assign miss    = ls_valid && !hit;
    assign stall   = (state_q != ST_IDLE) || miss;

    // Refill beats own the write port in FILL_DATA; otherwise a store hit may write
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ls_addr[WIN_AW-1:0];
        ram_wdata = ls_wdata;
        if (state_q == ST_FILL_DATA) begin
            if (sd_rvalid) begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = sd_rdata;
            end
        end else if (ls_valid && !ls_rnw && !stall) begin
            ram_we = 1'b1;
        end
    end

    win_ram #(
        .DW     (DW),
        .WIN_AW (WIN_AW)
    ) u_win_ram (
        .clk       (ref_clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .raddr_a_i (ls_addr[WIN_AW-1:0]),
        .rdata_a_o (stage_rdata),
        .raddr_b_i (cnt_q),
        .rdata_b_o (wb_rdata)
    );

    // Miss sequencer: writeback of a dirty window, then refill; SDRAM request outputs registered
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_tag_q   <= '0;
            win_valid_q <= 1'b0;
            dirty_q     <= 1'b0;
            cnt_q       <= '0;
            sd_req_q    <= 1'b0;
            sd_rnw_q    <= SD_WB;
            sd_addr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss) begin
                        cnt_q    <= '0;
                        sd_req_q <= 1'b1;
                        if (win_valid_q && dirty_q) begin
                            state_q   <= ST_WB_REQ;
                            sd_rnw_q  <= SD_WB;
                            sd_addr_q <= {win_tag_q, OFS_ZERO};
                        end else begin
                            // Window is being replaced: contents are stale until the last beat
                            state_q     <= ST_FILL_REQ;
                            sd_rnw_q    <= SD_FILL;
                            sd_addr_q   <= {req_tag, OFS_ZERO};
                            win_tag_q   <= req_tag;
                            win_valid_q <= 1'b0;
                        end
                    end else if (ls_valid && !ls_rnw) begin
                        dirty_q <= 1'b1;
                    end
                end
                ST_WB_REQ: begin
                    if (sd_ack) begin
                        state_q  <= ST_WB_DATA;
                        sd_req_q <= 1'b0;
                    end
                end
                ST_WB_DATA: begin
                    if (sd_wready) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            dirty_q     <= 1'b0;
                            state_q     <= ST_FILL_REQ;
                            sd_req_q    <= 1'b1;
                            sd_rnw_q    <= SD_FILL;
                            sd_addr_q   <= {req_tag, OFS_ZERO};
                            win_tag_q   <= req_tag;
                            win_valid_q <= 1'b0;
                        end
                    end
                end
                ST_FILL_REQ: begin
                    if (sd_ack) begin
                        state_q  <= ST_FILL_DATA;
                        sd_req_q <= 1'b0;
                    end
                end
                ST_FILL_DATA: begin
                    if (sd_rvalid) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            win_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // MEM/WB boundary registers: advance when not stalled, bubble tags/valid while stalled
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            pt_data_q  <= '0;
            pt_tag_q   <= '0;
            ls_tag_q   <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
        end else if (stall) begin
            pt_tag_q   <= '0;
            ls_tag_q   <= TW'(TAG_NONE);
            wb_valid_q <= 1'b0;
        end else begin
            pt_data_q <= pt_data_in;
            pt_tag_q  <= pt_tag_in;
            if (ls_valid && ls_rnw) begin
                ls_tag_q   <= ls_tag_in;
                wb_data_q  <= stage_rdata;
                wb_valid_q <= 1'b1;
            end else begin
                ls_tag_q   <= TW'(TAG_NONE);
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign pt_data_out   = pt_data_q;
    assign pt_tag_out    = pt_tag_q;
    assign ls_tag_out    = ls_tag_q;
    assign wb_data       = wb_data_q;
    assign wb_valid      = wb_valid_q;
    assign sd_req        = sd_req_q;
    assign sd_rnw        = sd_rnw_q;
    assign sd_start_addr = sd_addr_q;
    assign sd_length     = BURST_LEN;
    assign sd_wdata      = (state_q == ST_WB_DATA) ? wb_rdata : '0;

`ifdef MEM_PERF_CNT_EN
    logic [31:0] miss_cnt_q;
    logic [31:0] wb_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating event counters: misses and writebacks counted as IDLE is left
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && miss) begin
                miss_cnt_q <= sat_inc(miss_cnt_q);
                if (win_valid_q && dirty_q) begin
                    wb_cnt_q <= sat_inc(wb_cnt_q);
                end
            end
            if (stall) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign miss_cnt  = miss_cnt_q;
    assign wb_cnt    = wb_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign miss_cnt  = 32'd0;
    assign wb_cnt    = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_win.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_win
//  Purpose  : Directed self-checking bench for mem_stage_win with a small
//             hand-driven SDRAM controller.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage_win;

    logic         ref_clk = 1'b0;
    logic         rst;
    logic [47:0]  pt_data_in;
    logic [14:0]  pt_tag_in;
    logic [47:0]  pt_data_out;
    logic [14:0]  pt_tag_out;
    logic         ls_valid;
    logic         ls_rnw;
    logic [24:0]  ls_addr;
    logic [7:0]   ls_wdata;
    logic [4:0]   ls_tag_in;
    logic [4:0]   ls_tag_out;
    logic [7:0]   wb_data;
    logic         wb_valid;
    logic         stall;
    logic         sd_req;
    logic         sd_ack;
    logic         sd_rnw;
    logic [24:0]  sd_start_addr;
    logic [24:0]  sd_length;
    logic         sd_rvalid;
    logic [7:0]   sd_rdata;
    logic         sd_wready;
    logic [7:0]   sd_wdata;
    logic [31:0]  miss_cnt;
    logic [31:0]  wb_cnt;
    logic [31:0]  stall_cnt;

    int total   = 0;
    int bad     = 0;
    int n_stall = 0;

    mem_stage_win dut (
        .ref_clk       (ref_clk),
        .rst           (rst),
        .pt_data_in    (pt_data_in),
        .pt_tag_in     (pt_tag_in),
        .pt_data_out   (pt_data_out),
        .pt_tag_out    (pt_tag_out),
        .ls_valid      (ls_valid),
        .ls_rnw        (ls_rnw),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_tag_in     (ls_tag_in),
        .ls_tag_out    (ls_tag_out),
        .wb_data       (wb_data),
        .wb_valid      (wb_valid),
        .stall         (stall),
        .sd_req        (sd_req),
        .sd_ack        (sd_ack),
        .sd_rnw        (sd_rnw),
        .sd_start_addr (sd_start_addr),
        .sd_length     (sd_length),
        .sd_rvalid     (sd_rvalid),
        .sd_rdata      (sd_rdata),
        .sd_wready     (sd_wready),
        .sd_wdata      (sd_wdata),
        .miss_cnt      (miss_cnt),
        .wb_cnt        (wb_cnt),
        .stall_cnt     (stall_cnt)
    );

    always #5 ref_clk = ~ref_clk;

    // One clock: tally the stall level seen just before the edge, then sample 1ns after it
    task automatic tick();
        #1;
        if (stall === 1'b1) n_stall++;
        @(posedge ref_clk);
        #1;
    endtask

    // Bounded wait for the burst request
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_ack();
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
    endtask

    // 256 refill beats of i^key with one idle cycle before beat 50; reports leaked outputs
    task automatic fill_beats(input logic [7:0] key, output int leaks);
        logic [7:0] b;
        leaks = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 50) begin
                sd_rvalid = 1'b0;
                sd_rdata  = 8'hEE;
                tick();
                if (pt_tag_out !== 15'd0 || wb_valid !== 1'b0) leaks++;
            end
            b         = i[7:0];
            sd_rvalid = 1'b1;
            sd_rdata  = b ^ key;
            tick();
            if (pt_tag_out !== 15'd0 || wb_valid !== 1'b0) leaks++;
        end
        sd_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pt_data_in = '0; pt_tag_in = '0;
        ls_valid = 1'b0; ls_rnw = 1'b0; ls_addr = '0; ls_wdata = '0; ls_tag_in = '0;
        sd_ack = 1'b0; sd_rvalid = 1'b0; sd_rdata = '0; sd_wready = 1'b0;
        tick(); tick();
        total++; if (sd_req !== 1'b0) begin bad++; $display("FAIL rst_sd_req got=%0b want=0", sd_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", stall); end
        total++; if (wb_valid !== 1'b0 || wb_data !== 8'h00) begin bad++; $display("FAIL rst_wb got=%0b/%0h want=0/0", wb_valid, wb_data); end
        total++; if (pt_tag_out !== 15'd0 || pt_data_out !== 48'd0) begin bad++; $display("FAIL rst_pt got=%0h/%0h want=0/0", pt_tag_out, pt_data_out); end
        total++; if (sd_start_addr !== 25'd0 || ls_tag_out !== 5'd0) begin bad++; $display("FAIL rst_misc got=%0h/%0h want=0/0", sd_start_addr, ls_tag_out); end
        rst = 1'b0;
        tick();
        n_stall = 0;
    endtask

    task automatic test_fill_load();
        bit ok;
        int leaks;
        ls_valid = 1'b1; ls_rnw = 1'b1; ls_addr = 25'h0000123; ls_tag_in = 5'd5;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fill_stall got=%0b want=1", stall); end
        tick();
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL fill_req got=timeout want=sd_req"); end
        total++; if (sd_rnw !== 1'b1) begin bad++; $display("FAIL fill_rnw got=%0b want=1", sd_rnw); end
        total++; if (sd_start_addr !== 25'h0000100) begin bad++; $display("FAIL fill_base got=%0h want=100", sd_start_addr); end
        total++; if (sd_length !== 25'd256) begin bad++; $display("FAIL fill_len got=%0d want=256", sd_length); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fill_bubble got=%0b want=0", wb_valid); end
        // stray beat before the acknowledge must be ignored
        sd_rvalid = 1'b1; sd_rdata = 8'hFF;
        tick();
        sd_rvalid = 1'b0;
        do_ack();
        total++; if (sd_req !== 1'b0) begin bad++; $display("FAIL fill_req_drop got=%0b want=0", sd_req); end
        fill_beats(8'h00, leaks);
        total++; if (leaks != 0) begin bad++; $display("FAIL fill_leak got=%0d want=0", leaks); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fill_unstall got=%0b want=0", stall); end
        tick();
        total++; if (wb_data !== 8'h23 || wb_valid !== 1'b1) begin bad++; $display("FAIL fill_load got=%0h/%0b want=23/1", wb_data, wb_valid); end
        total++; if (ls_tag_out !== 5'd5) begin bad++; $display("FAIL fill_tag got=%0d want=5", ls_tag_out); end
        ls_valid = 1'b0;
        tick();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL fill_once got=%0b want=0", wb_valid); end
    endtask

    task automatic test_store_load();
        ls_valid = 1'b1; ls_rnw = 1'b0; ls_addr = 25'h0000110; ls_wdata = 8'hA5; ls_tag_in = 5'd9;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL st_stall got=%0b want=0", stall); end
        tick();
        total++; if (wb_valid !== 1'b0 || ls_tag_out !== 5'd0) begin bad++; $display("FAIL st_out got=%0b/%0d want=0/0", wb_valid, ls_tag_out); end
        ls_rnw = 1'b1; ls_tag_in = 5'd4; ls_wdata = 8'h00;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_stall got=%0b want=0", stall); end
        tick();
        total++; if (wb_data !== 8'hA5 || wb_valid !== 1'b1 || ls_tag_out !== 5'd4) begin bad++; $display("FAIL ld_after_st got=%0h/%0b/%0d want=a5/1/4", wb_data, wb_valid, ls_tag_out); end
        ls_valid = 1'b0;
        tick();
    endtask

    task automatic test_writeback();
        bit ok;
        int leaks;
        logic [7:0] want;
        ls_valid = 1'b1; ls_rnw = 1'b1; ls_addr = 25'h0000205; ls_tag_in = 5'd6;
        tick();
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL wb_req got=timeout want=sd_req"); end
        total++; if (sd_rnw !== 1'b0 || sd_start_addr !== 25'h0000100) begin bad++; $display("FAIL wb_hdr got=%0b/%0h want=0/100", sd_rnw, sd_start_addr); end
        // stray ready before the acknowledge must be ignored
        sd_wready = 1'b1;
        tick();
        sd_wready = 1'b0;
        do_ack();
        for (int i = 0; i < 256; i++) begin
            want = (i == 16) ? 8'hA5 : i[7:0];
            if (i == 77) begin
                sd_wready = 1'b0;
                tick();
                total++; if (sd_wdata !== want) begin bad++; $display("FAIL wb_hold got=%0h want=%0h", sd_wdata, want); end
            end
            sd_wready = 1'b1;
            total++; if (sd_wdata !== want) begin bad++; $display("FAIL wb_beat%0d got=%0h want=%0h", i, sd_wdata, want); end
            tick();
        end
        sd_wready = 1'b0;
        total++; if (sd_req !== 1'b1 || sd_rnw !== 1'b1 || sd_start_addr !== 25'h0000200) begin bad++; $display("FAIL wb_refill_hdr got=%0b/%0b/%0h want=1/1/200", sd_req, sd_rnw, sd_start_addr); end
        do_ack();
        fill_beats(8'h5A, leaks);
        total++; if (leaks != 0) begin bad++; $display("FAIL wb_leak got=%0d want=0", leaks); end
        tick();
        total++; if (wb_data !== 8'h5F || wb_valid !== 1'b1 || ls_tag_out !== 5'd6) begin bad++; $display("FAIL wb_replay got=%0h/%0b/%0d want=5f/1/6", wb_data, wb_valid, ls_tag_out); end
        ls_valid = 1'b0;
        tick();
`ifdef MEM_PERF_CNT_EN
        total++; if (miss_cnt !== 32'd2) begin bad++; $display("FAIL perf_miss got=%0d want=2", miss_cnt); end
        total++; if (wb_cnt !== 32'd1) begin bad++; $display("FAIL perf_wb got=%0d want=1", wb_cnt); end
        total++; if (stall_cnt !== 32'(n_stall)) begin bad++; $display("FAIL perf_stall got=%0d want=%0d", stall_cnt, n_stall); end
`else
        total++; if (miss_cnt !== 32'd0 || wb_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_off got=%0d/%0d/%0d want=0/0/0", miss_cnt, wb_cnt, stall_cnt); end
`endif
    endtask

    task automatic test_passthrough();
        bit ok;
        int leaks;
        pt_data_in = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        pt_tag_in  = {5'd4, 5'd2, 5'd1};
        tick();
        total++; if (pt_data_out !== {16'hCCCC, 16'hBBBB, 16'hAAAA} || pt_tag_out !== {5'd4, 5'd2, 5'd1}) begin bad++; $display("FAIL pt_flow got=%0h/%0h", pt_data_out, pt_tag_out); end
        pt_data_in = {16'h3333, 16'h2222, 16'h1111};
        pt_tag_in  = {5'd9, 5'd7, 5'd3};
        ls_valid = 1'b1; ls_rnw = 1'b1; ls_addr = 25'h0000305; ls_tag_in = 5'd7;
        tick();
        total++; if (pt_tag_out !== 15'd0) begin bad++; $display("FAIL pt_bubble got=%0h want=0", pt_tag_out); end
        total++; if (pt_data_out !== {16'hCCCC, 16'hBBBB, 16'hAAAA}) begin bad++; $display("FAIL pt_hold got=%0h want=ccccbbbbaaaa", pt_data_out); end
        wait_req(ok);
        total++; if (!ok || sd_rnw !== 1'b1 || sd_start_addr !== 25'h0000300) begin bad++; $display("FAIL pt_req got=%0b/%0b/%0h want=1/1/300", ok, sd_rnw, sd_start_addr); end
        do_ack();
        fill_beats(8'hC3, leaks);
        total++; if (leaks != 0) begin bad++; $display("FAIL pt_leak got=%0d want=0", leaks); end
        tick();
        total++; if (pt_data_out !== {16'h3333, 16'h2222, 16'h1111} || pt_tag_out !== {5'd9, 5'd7, 5'd3}) begin bad++; $display("FAIL pt_emit got=%0h/%0h", pt_data_out, pt_tag_out); end
        total++; if (wb_data !== 8'hC6 || wb_valid !== 1'b1 || ls_tag_out !== 5'd7) begin bad++; $display("FAIL pt_load got=%0h/%0b/%0d want=c6/1/7", wb_data, wb_valid, ls_tag_out); end
        pt_tag_in = '0;
        ls_valid  = 1'b0;
        tick();
        total++; if (wb_valid !== 1'b0 || pt_tag_out !== 15'd0) begin bad++; $display("FAIL pt_once got=%0b/%0h want=0/0", wb_valid, pt_tag_out); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int leaks;
        logic [7:0] b;
        ls_valid = 1'b1; ls_rnw = 1'b1; ls_addr = 25'h0000423; ls_tag_in = 5'd3;
        tick();
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_req got=timeout want=sd_req"); end
        do_ack();
        for (int i = 0; i < 100; i++) begin
            b = i[7:0];
            sd_rvalid = 1'b1; sd_rdata = b;
            tick();
        end
        sd_rdata = 8'd100;
        #2;
        rst = 1'b1; ls_valid = 1'b0; sd_rvalid = 1'b0;
        #1;
        total++; if (sd_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rm_ctl got=%0b/%0b want=0/0", sd_req, stall); end
        total++; if (wb_valid !== 1'b0 || wb_data !== 8'h00 || ls_tag_out !== 5'd0) begin bad++; $display("FAIL rm_wb got=%0b/%0h/%0d want=0/0/0", wb_valid, wb_data, ls_tag_out); end
        total++; if (pt_data_out !== 48'd0 || pt_tag_out !== 15'd0 || sd_start_addr !== 25'd0 || sd_wdata !== 8'd0) begin bad++; $display("FAIL rm_out got=%0h/%0h/%0h/%0h want=0", pt_data_out, pt_tag_out, sd_start_addr, sd_wdata); end
`ifdef MEM_PERF_CNT_EN
        total++; if (miss_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++; $display("FAIL rm_perf got=%0d/%0d want=0/0", miss_cnt, stall_cnt); end
`endif
        tick(); tick();
        rst = 1'b0;
        ls_valid = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rm_remiss got=%0b want=1", stall); end
        tick();
        total++; if (sd_req !== 1'b1 || sd_rnw !== 1'b1 || sd_start_addr !== 25'h0000400) begin bad++; $display("FAIL rm_rereq got=%0b/%0b/%0h want=1/1/400", sd_req, sd_rnw, sd_start_addr); end
        do_ack();
        fill_beats(8'h00, leaks);
        tick();
        total++; if (wb_data !== 8'h23 || wb_valid !== 1'b1 || ls_tag_out !== 5'd3) begin bad++; $display("FAIL rm_replay got=%0h/%0b/%0d want=23/1/3", wb_data, wb_valid, ls_tag_out); end
        ls_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_load();
        test_store_load();
        test_writeback();
        test_passthrough();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_win.md
Name: mem_stage_win

Overview:
Parametrised successor of the pipeline memory stage. It holds one window of SDRAM data in a local byte array and serves loads and stores from it. A miss stalls the pipeline while the block writes back the dirty window and refills from SDRAM. It also registers NCH pass-through result channels into the MEM/WB boundary.

Parameters:
DW, 8, data byte width of memory and ls_wdata/wb_data
AW, 25, SDRAM byte address width
WIN_AW, 8, log2 window size in bytes (window = 2^WIN_AW)
NCH, 3, number of pass-through result channels (ALU0, ALU1, MUL)
PW, 16, pass-through result width
TW, 5, register tag width; tag 0 = no writeback

Ports:
ref_clk  in  1  clock
rst  in  1  asynchronous reset, active-high
pt_data_in  in  NCH*PW  pass-through results, channel i at [i*PW +: PW]
pt_tag_in  in  NCH*TW  pass-through Rd tags
pt_data_out  out  NCH*PW  registered pass-through results
pt_tag_out  out  NCH*TW  registered tags
ls_valid  in  1  load/store present
ls_rnw  in  1  1=load, 0=store
ls_addr  in  AW  byte address
ls_wdata  in  DW  store data
ls_tag_in  in  TW  load destination tag
ls_tag_out  out  TW  registered load tag
wb_data  out  DW  registered load data
wb_valid  out  1  wb_data valid this cycle
stall  out  1  freeze upstream; inputs must be held stable
sd_req  out  1  burst request, held until sd_ack
sd_ack  in  1  one-cycle acceptance by SDRAM controller
sd_rnw  out  1  1=fill (read SDRAM), 0=writeback
sd_start_addr  out  AW  burst base {win_tag, WIN_AW'b0}
sd_length  out  AW  burst length, always 2^WIN_AW
sd_rvalid  in  1  fill beat valid
sd_rdata  in  DW  fill beat
sd_wready  in  1  controller consumes sd_wdata this cycle
sd_wdata  out  DW  writeback beat
miss_cnt, wb_cnt, stall_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- State: win_tag[AW-WIN_AW], win_valid, dirty, beat counter cnt[WIN_AW], FSM {IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA}.
- hit = win_valid && ls_addr[AW-1:WIN_AW]==win_tag; miss = ls_valid && !hit.
- stall = (state==IDLE && miss) || state!=IDLE. It is combinational.
- Reset (async): state=IDLE, win_valid=0, dirty=0, cnt=0, all outputs 0, sd_req=0.
- Latency is 1 cycle. With stall=0, at the edge: pt_*_out<=pt_*_in. On a load hit: ls_tag_out<=ls_tag_in, wb_data<=array[ls_addr[WIN_AW-1:0]], wb_valid<=1. On a store hit: array written, dirty<=1, ls_tag_out<=0, wb_valid<=0.
- With stall=1, at the edge: pt_tag_out, ls_tag_out and wb_valid <= 0 (bubble). pt_data_out holds. Held upstream operands are emitted exactly once, in the cycle stall drops.
- IDLE & miss: go to WB_REQ if win_valid&&dirty, else FILL_REQ; cnt<=0.
- WB_REQ: sd_req=1, sd_rnw=0, sd_start_addr uses the old win_tag. On sd_ack go to WB_DATA.
- WB_DATA: sd_wdata=array[cnt] is valid in any cycle of the state. On sd_wready, cnt++. On the last beat (cnt==2^WIN_AW-1 && sd_wready): dirty<=0, cnt<=0, go to FILL_REQ.
- FILL_REQ: win_tag<=ls_addr[AW-1:WIN_AW] on entry. sd_req=1, sd_rnw=1. On sd_ack go to FILL_DATA.
- FILL_DATA: on sd_rvalid, array[cnt]<=sd_rdata, cnt++. On the last beat: win_valid<=1, go to IDLE. The held access then hits, stall drops, and it completes.
- sd_rvalid/sd_wready outside FILL_DATA/WB_DATA are ignored. sd_ack outside *_REQ is ignored.
- A store miss writes ls_wdata only after the refill, during the replay hit.
- ls_valid=0 never stalls. Pass-through flows every non-stalled cycle.
- rst mid-burst aborts and discards the window contents. The SDRAM controller shares rst.
- cnt wraps naturally at 2^WIN_AW. The last-beat test uses the all-ones count.

Optional Feature:
MEM_PERF_CNT_EN.
- Defined: miss_cnt increments per miss (IDLE->non-IDLE), wb_cnt per writeback burst, stall_cnt per cycle with stall=1. All saturate at 2^32-1 and clear on rst.
- Undefined: the three ports are tied to 0 and no counter logic is generated.

Decomposition:
- Package mem_stage_pkg: FSM state enum, sd_rnw encodings (SD_FILL=1, SD_WB=0), TAG_NONE=0.
- One sub-module, win_ram: a 2^WIN_AW x DW array with one write port and two read ports (stage read, writeback read).
- FSM, counters and output registers stay in mem_stage_win.

Test Plan:
- After reset, load addr 0x0000123 -> stall=1; FILL_REQ with sd_start_addr=0x0000100, sd_length=256, sd_rnw=1. Feed 256 beats i->i. Next cycle wb_data=0x23, wb_valid=1, ls_tag_out=ls_tag_in.
- Store 0xA5 to 0x0000110, then load 0x0000110 -> wb_data=0xA5, no stall, 1-cycle latency each.
- Dirty window, load 0x0000205 -> WB burst base 0x0000100: 256 beats with beat 0x10=0xA5. Then fill base 0x0000200 and replay.
- Pass-through tags {3,7,9}, data {0x1111,0x2222,0x3333} held during a 260-cycle miss -> pt_tag_out=0 while stalled; the values appear exactly once after stall drops.
- Assert rst during FILL_DATA beat 100 -> all outputs 0, sd_req=0, IDLE. A reload of the same address misses again.
- With MEM_PERF_CNT_EN, the three-access sequence above -> miss_cnt=2, wb_cnt=1, stall_cnt equals the counted stalled cycles.
